// File: rtl/spi_slave_frame_rx_pkg.sv
// Shared constants and FSM encoding for the SPI Mode-0 frame receiver.
// Field widths default to a 16-bit {CMD, ADDR, PAYLOAD} master frame.
package spi_slave_frame_rx_pkg;

    localparam int DEF_CMD_BITS     = 1;
    localparam int DEF_ADDR_BITS    = 8;
    localparam int DEF_PAYLOAD_BITS = 7;

    localparam logic CS_ASSERT   = 1'b0;
    localparam logic CS_DEASSERT = 1'b1;
    localparam logic CMD_WRITE   = 1'b1;
    localparam logic CMD_READ    = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizer for level inputs plus a third-flop edge detector
// on one clock-like input (rise/fall pulses in the i_clk domain).
module spi_sync_edge #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_edge,
    output logic             o_rise,
    output logic             o_fall,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;
    logic [2:0]       r_e;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d1 <= RST_VAL;
            r_d2 <= RST_VAL;
            r_e  <= '0;
        end else begin
            r_d1 <= i_d;
            r_d2 <= r_d1;
            r_e  <= {r_e[1:0], i_edge};
        end
    end

    assign o_q    = r_d2;
    assign o_rise = r_e[1] & ~r_e[2];
    assign o_fall = ~r_e[1] & r_e[2];

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI Mode-0 slave: oversampled deframer for {CMD, ADDR, PAYLOAD} frames,
// issuing register write strobes or read requests with MISO readback.
module spi_slave_frame_rx
    import spi_slave_frame_rx_pkg::*;
#(
    parameter int CMD_BITS     = DEF_CMD_BITS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    o_wr_en,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_wr_data,
    output logic                    o_rd_req,
    input  logic [PAYLOAD_BITS-1:0] i_rd_data,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_CMD   = CW'(CMD_BITS);
    localparam logic [CW-1:0] CNT_ADDR  = CW'(CMD_BITS + ADDR_BITS);
    localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_BITS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_rx_sr;
    logic [PAYLOAD_BITS-1:0] r_tx_sr;
    logic                    r_miso;
    logic                    r_wr_en;
    logic                    r_rd_req;
    logic                    r_frame_err;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [PAYLOAD_BITS-1:0] r_wr_data;

    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_cs;
    logic                    w_mosi;
    logic [CW-1:0]           w_cnt_nxt;
    logic [FRAME_BITS-1:0]   w_rx_next;
    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_start;
    logic                    w_shift;
    logic                    w_tx_shift;
    logic                    w_rd;
    logic                    w_done;
    logic                    w_abort;
    logic                    w_wr_cmd;

    spi_sync_edge #(
        .WIDTH   (2),
        .RST_VAL ({1'b0, CS_DEASSERT})
    ) u_sync (
        .i_clk   (sysclk),
        .i_rst_n (rst_n),
        .i_edge  (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall),
        .i_d     ({mosi, cs}),
        .o_q     ({w_mosi, w_cs})
    );

    assign w_cnt_nxt = r_bit_cnt + 1'b1;
    assign w_rx_next = {r_rx_sr[FRAME_BITS-2:0], w_mosi};
    assign w_wr_cmd  = w_frame[FRAME_BITS-1 -: CMD_BITS]
                       == CMD_BITS'(CMD_WRITE);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_tx_shift  = 1'b0;
        w_rd        = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_frame     = r_rx_sr;
        if (w_cs != CS_ASSERT) begin
            w_state_nxt = S_IDLE;
            if (r_state == S_HOLD) begin
                w_done = 1'b1;
            end else if (r_state == S_DATA && r_bit_cnt == CNT_LAST) begin
                // Master dropped cs before the last rise: take mosi as is.
                w_done  = 1'b1;
                w_frame = w_rx_next;
            end else if (r_state != S_IDLE) begin
                w_abort = 1'b1;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARM;
                    w_start     = 1'b1;
                end
                S_ARM: if (w_sclk_fall) w_state_nxt = S_CMD;
                S_CMD: if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (w_cnt_nxt == CNT_CMD) w_state_nxt = S_ADDR;
                end
                S_ADDR: if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (w_cnt_nxt == CNT_ADDR) begin
                        w_state_nxt = S_DATA;
                        w_rd = w_rx_next[ADDR_BITS +: CMD_BITS]
                               == CMD_BITS'(CMD_READ);
                    end
                end
                S_DATA: begin
                    w_tx_shift = w_sclk_fall;
                    if (w_sclk_rise) begin
                        w_shift = 1'b1;
                        if (w_cnt_nxt == CNT_FRAME) w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: w_state_nxt = S_HOLD;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_miso      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_req    <= 1'b0;
            r_frame_err <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_req    <= 1'b0;
            r_frame_err <= w_abort;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
                r_tx_sr   <= '0;
            end
            if (w_shift) begin
                r_rx_sr   <= w_rx_next;
                r_bit_cnt <= w_cnt_nxt;
            end
            if (w_rd) begin
                r_addr   <= w_rx_next[ADDR_BITS-1:0];
                r_rd_req <= 1'b1;
            end
            if (r_rd_req) begin
                r_tx_sr <= i_rd_data;
            end else if (w_tx_shift) begin
                r_miso  <= r_tx_sr[PAYLOAD_BITS-1];
                r_tx_sr <= {r_tx_sr[PAYLOAD_BITS-2:0], 1'b0};
            end
            if (w_state_nxt != S_DATA) r_miso <= 1'b0;
            if (w_done && w_wr_cmd) begin
                r_wr_en   <= 1'b1;
                r_addr    <= w_frame[PAYLOAD_BITS +: ADDR_BITS];
                r_wr_data <= w_frame[PAYLOAD_BITS-1:0];
            end
        end
    end

    assign miso        = r_miso && r_state == S_DATA && w_cs == CS_ASSERT;
    assign o_wr_en     = r_wr_en;
    assign o_rd_req    = r_rd_req;
    assign o_frame_err = r_frame_err;
    assign o_addr      = r_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = r_state != S_IDLE;

endmodule
